// File: rtl/piano_key_scheduler.sv
// Merges keyboard/autoplay key events into a shadow key vector, committed to the renderer-visible vector at frame start.
// Build option: define FIXED_PRIORITY_EN to make requester A always win (default is round-robin).
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_RUN     | accept events (one per cycle), honour clear-all and frame start
// ST_COMMIT  | single cycle: copy shadow to active, all requesters stalled
module piano_key_scheduler #(
    parameter int KEY_COUNT = 84,
    parameter int IDX_W     = 7
) (
    input  logic             iClk,
    input  logic             iReset,
    input  logic             iReqA_valid,
    input  logic [IDX_W-1:0] iReqA_key,
    input  logic             iReqA_press,
    output logic             oReqA_ready,
    input  logic             iReqB_valid,
    input  logic [IDX_W-1:0] iReqB_key,
    input  logic             iReqB_press,
    output logic             oReqB_ready,
    input  logic             iFrameStart,
    input  logic             iClearAll,
    input  logic [IDX_W-1:0] iRdKey,
    output logic             oRdPressed,
    output logic             oPending,
    output logic [7:0]       oErrCount
);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_COMMIT = 1'b1;
    localparam logic [IDX_W:0] KEY_LIMIT = KEY_COUNT[IDX_W:0];

    logic [0:0]           state_q, state_d;
    logic [KEY_COUNT-1:0] shadow_q, shadow_d;
    logic [KEY_COUNT-1:0] active_q, active_d;
    logic [7:0]           err_cnt_q, err_cnt_d;
    logic                 rd_pressed_q, rd_pressed_d;
`ifndef FIXED_PRIORITY_EN
    logic                 ptr_b_q, ptr_b_d;
`endif

    logic             grant_a;
    logic             grant_b;
    logic             xfer;
    logic [IDX_W-1:0] sel_key;
    logic             sel_press;
    logic             sel_key_ok;

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state_q == ST_RUN && !iFrameStart && !iClearAll && !iReset) begin
`ifdef FIXED_PRIORITY_EN
            grant_a = iReqA_valid;
            grant_b = iReqB_valid && !iReqA_valid;
`else
            if (iReqA_valid && iReqB_valid) begin
                grant_a = !ptr_b_q;
                grant_b = ptr_b_q;
            end else begin
                grant_a = iReqA_valid;
                grant_b = iReqB_valid;
            end
`endif
        end
    end

    assign xfer       = grant_a || grant_b;
    assign sel_key    = grant_a ? iReqA_key : iReqB_key;
    assign sel_press  = grant_a ? iReqA_press : iReqB_press;
    assign sel_key_ok = {1'b0, sel_key} < KEY_LIMIT;

    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        active_d     = active_q;
        err_cnt_d    = err_cnt_q;
        rd_pressed_d = ({1'b0, iRdKey} < KEY_LIMIT) ? active_q[iRdKey] : 1'b0;
`ifndef FIXED_PRIORITY_EN
        ptr_b_d = ptr_b_q;
        if (grant_a) begin
            ptr_b_d = 1'b1;
        end else if (grant_b) begin
            ptr_b_d = 1'b0;
        end
`endif
        case (state_q)
            ST_RUN: begin
                // Clear and event are exclusive: a clear cycle never grants.
                if (iClearAll) begin
                    shadow_d = '0;
                end else if (xfer && sel_key_ok) begin
                    shadow_d[sel_key] = sel_press;
                end
                if (xfer && !sel_key_ok && err_cnt_q != 8'hFF) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
                if (iFrameStart) begin
                    state_d = ST_COMMIT;
                end
            end
            default: begin
                active_d = shadow_q;
                state_d  = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q      <= ST_RUN;
            shadow_q     <= '0;
            active_q     <= '0;
            err_cnt_q    <= '0;
            rd_pressed_q <= 1'b0;
`ifndef FIXED_PRIORITY_EN
            ptr_b_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            err_cnt_q    <= err_cnt_d;
            rd_pressed_q <= rd_pressed_d;
`ifndef FIXED_PRIORITY_EN
            ptr_b_q      <= ptr_b_d;
`endif
        end
    end

    assign oReqA_ready = grant_a;
    assign oReqB_ready = grant_b;
    assign oRdPressed  = rd_pressed_q;
    assign oPending    = shadow_q != active_q;
    assign oErrCount   = err_cnt_q;

endmodule

// File: doc/piano_key_scheduler.md
# piano_key_scheduler

Arbitrates key press/release events from two requesters (keyboard decoder, autoplay sequencer) into one shared per-key state vector that the piano VGA renderer reads. Events collect in a shadow vector; the active vector seen by the renderer updates only at frame start, so a key never changes colour mid-frame. Sits between the input front-ends and the 1024x768 piano renderer, in the renderer's pixel clock domain.

## Interface
Parameters:
- KEY_COUNT, 84, number of keys (49 main + 35 half); valid indices 0..KEY_COUNT-1
- IDX_W, 7, key index width

Ports:
- iClk  in  1  pixel clock (65 MHz); one clock; all logic on rising edge
- iReset  in  1  synchronous, active-high reset
- iReqA_valid  in  1  requester A (keyboard) event valid
- iReqA_key  in  IDX_W  key index for A
- iReqA_press  in  1  1 = press, 0 = release
- oReqA_ready  out  1  A event accepted this cycle
- iReqB_valid, iReqB_key, iReqB_press, oReqB_ready  as A, requester B (autoplay)
- iFrameStart  in  1  one-cycle pulse at start of vertical blanking
- iClearAll  in  1  one-cycle pulse: release all keys in shadow
- iRdKey  in  IDX_W  renderer lookup index
- oRdPressed  out  1  active[iRdKey], registered
- oPending  out  1  shadow differs from active
- oErrCount  out  8  out-of-range events accepted, saturating

## Operation
- FSM states RUN, COMMIT. Reset -> RUN.
- RUN: at most one grant per cycle. Grant allowed only if !iFrameStart && !iClearAll. Both valid: round-robin, pointer toggles to the other requester after each grant; after reset A has priority. Single valid: granted.
- ready is combinational: oReqX_ready = RUN && grant to X. Transfer = valid && ready. Requester holds valid/key/press stable until transfer.
- Accepted event with key < KEY_COUNT: shadow[key] <= press. Key >= KEY_COUNT: accepted, shadow unchanged, oErrCount += 1 saturating at 255.
- iClearAll in RUN: shadow <= 0; no grant that cycle. iClearAll in COMMIT: ignored.
- iFrameStart in RUN: no grant; next state COMMIT (also applies if iClearAll same cycle: clear happens, then commit copies cleared shadow).
- COMMIT (exactly one cycle): active <= shadow; both readys low; iFrameStart ignored; -> RUN.
- oRdPressed <= (iRdKey < KEY_COUNT) ? active[iRdKey] : 0.
- oPending = (shadow != active), combinational from registers.
- Reset clears shadow, active, oErrCount, oRdPressed, pointer (A first); state RUN; all readys low while iReset high.

## Timing
- Accepted event -> shadow update next edge; visible in active at edge ending the next COMMIT cycle (earliest: event cycle N, iFrameStart N+1, COMMIT N+2, active updated at end of N+2).
- Event and iFrameStart in same cycle: event stalled (ready low), accepted no earlier than first RUN cycle after COMMIT.
- Read latency: 1 cycle from iRdKey to oRdPressed.
- Throughput: one event per cycle in RUN; zero during frame-start and COMMIT cycles.
- Reset asserted mid-COMMIT: reset wins; active not updated.

## Configuration
- FIXED_PRIORITY_EN defined: A always wins over B when both valid; pointer logic removed; B can starve.
- Undefined (default): round-robin as above.

## Test plan
- Reset, then A press key 10, iFrameStart, wait 2 cycles, iRdKey=10 -> oRdPressed=1 one cycle later; oPending 1 after event, 0 after COMMIT.
- A and B both valid 4 cycles (keys 3, 5): grants A,B,A,B; with FIXED_PRIORITY_EN: A,A,A,A and oReqB_ready stays 0.
- B press key 90 -> ready=1, shadow unchanged, oErrCount=1; 300 such events -> oErrCount=255.
- A valid with iFrameStart same cycle -> ready 0 that cycle and COMMIT cycle, accepted following cycle; active excludes it until next frame.
- Keys 0 and 83 pressed and committed, iClearAll + iFrameStart same cycle -> after COMMIT both read 0; iRdKey=100 -> 0.
- iReset during COMMIT with shadow key 7 set -> active, shadow, oRdPressed all 0, state RUN.
